// File: rtl/accdnn_blob_pkg.sv
// Shared sizing helpers for the blob output path: widths, beat counts and frame length.
package accdnn_blob_pkg;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (longint unsigned v = 1; v < longint'(n); v = v << 1) begin
         r++;
      end
      return r;
   endfunction

   // Index width that never collapses to zero bits, so single-entry ranges still get a register.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n <= 2) ? 1 : clog2(n);
   endfunction

   function automatic int unsigned lane_bits(input int unsigned dw, input int unsigned lanes);
      return dw * lanes;
   endfunction

   function automatic int unsigned beats_per_word(input int unsigned kpf,
                                                  input int unsigned out_lanes);
      return kpf / out_lanes;
   endfunction

   function automatic int unsigned words_per_frame(input int unsigned w, input int unsigned h,
                                                   input int unsigned kg);
      return w * h * kg;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; a pop that coincides with a push frees room for it even when full.
module sync_fifo_fwft
   import accdnn_blob_pkg::*;
#(
   parameter int unsigned WIDTH = 33,
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata_c,
   output logic [clog2(DEPTH):0]  count_next_c,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             wr_ok;
   logic             rd_ok;

   always_comb begin
      rd_ok        = pop & ~empty;
      wr_ok        = push & (~full | rd_ok);
      count_next_c = count + CW'(wr_ok) - CW'(rd_ok);
      rdata_c      = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers, occupancy and registered full/empty flags
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_next_c;
         full  <= (count_next_c == CW'(DEPTH));
         empty <= (count_next_c == '0);
      end
   end

endmodule

// File: rtl/blob_out_packer.sv
// Buffers KPF-lane result words and re-emits them as OUT_LANES-wide beats with
// backpressure, frame-length checking and overflow detection.
module blob_out_packer
   import accdnn_blob_pkg::*;
#(
   parameter int unsigned DW          = 16,
   parameter int unsigned KPF         = 2,
   parameter int unsigned OUT_LANES   = 1,
   parameter int unsigned DB_W_OUT    = 4,
   parameter int unsigned DB_H_OUT    = 4,
   parameter int unsigned KG          = 2,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned RDY_MARGIN  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_en,
   input  logic                      in_eop,
   input  logic [KPF*DW-1:0]         in_data,
   output logic                      in_rdy,
   input  logic                      out_rdy,
   output logic                      out_en,
   output logic                      out_eop,
   output logic [OUT_LANES*DW-1:0]   out_data,
   output logic                      ovf_err,
   output logic                      eop_err
);

   localparam int unsigned IN_W  = lane_bits(DW, KPF);
   localparam int unsigned OUT_W = lane_bits(DW, OUT_LANES);
   localparam int unsigned BEATS = beats_per_word(KPF, OUT_LANES);
   localparam int unsigned WPF   = words_per_frame(DB_W_OUT, DB_H_OUT, KG);
   localparam int unsigned IW    = idx_w(BEATS);
   localparam int unsigned FW    = idx_w(WPF);
   localparam int unsigned CW    = clog2(FIFO_DEPTH) + 1;

   logic [IN_W:0]      fifo_rdata;
   logic [CW-1:0]      fifo_count_next;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_pop;

   logic [IN_W-1:0]    head_data;
   logic               head_eop;
   logic [OUT_W-1:0]   beat_next;
   logic               load;
   logic               last_beat;
   logic               frame_end;
   logic               push_drop;

   logic               beat_valid;
   logic               beat_eop;
   logic [OUT_W-1:0]   beat_data;
   logic [IW-1:0]      beat_idx;
   logic [FW-1:0]      word_cnt;
   logic               in_rdy_q;
   logic               ovf_q;
   logic               eop_q;

   // Every in_en is offered to the FIFO; the controller only sees in_rdy after a pipeline delay.
   sync_fifo_fwft #(
      .WIDTH (IN_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push         (in_en),
      .pop          (fifo_pop),
      .wdata        ({in_eop, in_data}),
      .rdata_c      (fifo_rdata),
      .count_next_c (fifo_count_next),
      .full         (fifo_full),
      .empty        (fifo_empty)
   );

   always_comb begin
      head_data = fifo_rdata[IN_W-1:0];
      head_eop  = fifo_rdata[IN_W];
      out_en    = beat_valid & out_rdy;
      out_eop   = out_en & beat_eop;
      load      = ~fifo_empty & (~beat_valid | out_en);
      last_beat = (beat_idx == IW'(BEATS - 1));
      fifo_pop  = load & last_beat;
      push_drop = in_en & fifo_full & ~fifo_pop;
      frame_end = (word_cnt == FW'(WPF - 1));
      beat_next = '0;
      for (int unsigned b = 0; b < BEATS; b++) begin
         if (beat_idx == IW'(b)) begin
            beat_next = head_data[b*OUT_W +: OUT_W];
         end
      end
   end

   // Beat register: reloads only when empty or when the current beat is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_valid <= 1'b0;
         beat_eop   <= 1'b0;
         beat_data  <= '0;
         beat_idx   <= '0;
      end else if (load) begin
         beat_valid <= 1'b1;
         beat_data  <= beat_next;
         beat_eop   <= last_beat & head_eop;
         beat_idx   <= last_beat ? '0 : beat_idx + IW'(1);
      end else if (out_en) begin
         beat_valid <= 1'b0;
      end
   end

   // Frame counter, sticky error flags and registered ready
   always_ff @(posedge clk) begin
      if (rst) begin
         word_cnt <= '0;
         in_rdy_q <= 1'b0;
         ovf_q    <= 1'b0;
         eop_q    <= 1'b0;
      end else begin
         in_rdy_q <= (fifo_count_next < CW'(FIFO_DEPTH - RDY_MARGIN));
         if (in_en) begin
            if (in_eop || frame_end) begin
               word_cnt <= '0;
               if (in_eop != frame_end) begin
                  eop_q <= 1'b1;
               end
            end else begin
               word_cnt <= word_cnt + FW'(1);
            end
         end
         if (push_drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign out_data = beat_data;
   assign in_rdy   = in_rdy_q;
   assign ovf_err  = ovf_q;
   assign eop_err  = eop_q;

endmodule
